// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU and loader share one single-ported memory.
// Round-robin tie break with a bounded locked-burst override for the loader.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic                  ld_lock,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ack,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_CPU,
    GRANT_LD,
    ACK_CPU,
    ACK_LD
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         burst_q, burst_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

  logic lock_win;
  logic tie_ld;
  logic grant_cpu;
  logic grant_ld;

  // last_q == 1 means the loader was granted most recently
  assign lock_win  = last_q & ld_lock & (burst_q < MAXB);
  assign tie_ld    = ~last_q | lock_win;
  assign grant_cpu = cpu_req & (~ld_req | ~tie_ld);
  assign grant_ld  = ld_req & (~cpu_req | tie_ld);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_d     = burst_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_cpu: begin
            state_d = GRANT_CPU;
            last_d  = 1'b0;
            burst_d = '0;
          end
          grant_ld: begin
            state_d = GRANT_LD;
            last_d  = 1'b1;
            if (!ld_lock)
              burst_d = '0;
            else if (burst_q != MAXB)
              burst_d = burst_q + 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      GRANT_CPU: begin
        state_d = ACK_CPU;
        if (!cpu_we) cpu_rdata_d = mem_read_data;
      end
      GRANT_LD: begin
        state_d = ACK_LD;
        if (!ld_we) ld_rdata_d = mem_read_data;
      end
      ACK_CPU: state_d = IDLE;
      ACK_LD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Strobes decode straight from the state flop so a reset kills them at once
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    unique case (state_q)
      GRANT_CPU: begin
        mem_address    = cpu_addr;
        mem_write_data = cpu_wdata;
        mem_write      = cpu_we;
        mem_read       = ~cpu_we;
      end
      GRANT_LD: begin
        mem_address    = ld_addr;
        mem_write_data = ld_wdata;
        mem_write      = ld_we;
        mem_read       = ~ld_we;
      end
      default: begin
        mem_address    = '0;
        mem_write_data = '0;
      end
    endcase
  end

  assign cpu_ack   = (state_q == ACK_CPU);
  assign ld_ack    = (state_q == ACK_LD);
  assign busy      = (state_q != IDLE);
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, ack scoreboard, memory model.
// Expected ack order and read data are pushed up front and popped on each ack.
module tb_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          ld_req, ld_we, ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_read_data = mem[mem_address];

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       who;
    bit       rd;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cpu_ack_cyc = 0;
  int ld_ack_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(bit who, bit rd, logic [7:0] d);
    exp_t e;
    e.who = who;
    e.rd = rd;
    e.data = d;
    q.push_back(e);
  endtask

  // Monitor: every ack pops the next expected access
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst === 1'b1) begin
      if (mem_read && mem_write)
        chk("strobe_overlap", {mem_read, mem_write}, 2'b00);
      if (cpu_ack || ld_ack) begin
        if (cpu_ack) cpu_ack_cyc = cyc;
        if (ld_ack) ld_ack_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_ack", {cpu_ack, ld_ack}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("ack_who", {cpu_ack, ld_ack}, e.who ? 2'b01 : 2'b10);
          if (e.rd)
            chk("ack_rdata", e.who ? ld_rdata : cpu_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(logic [AW-1:0] a, logic [DW-1:0] d);
    @(posedge clk);
    #1;
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, cpu_ack, ld_ack, mem_read, mem_write}, 5'b0);
    chk("rst_bus", {mem_address, mem_write_data}, '0);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, '0);
    rst = 1'b1;
  endtask

  task automatic cpu_access(bit we, logic [AW-1:0] a, logic [DW-1:0] d,
                            bit hold);
    bit got = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ack) begin got = 1; break; end
    end
    if (!got) chk("cpu_ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) cpu_req = 0;
  endtask

  task automatic ld_access(bit we, bit lk, logic [AW-1:0] a,
                           logic [DW-1:0] d, bit hold);
    bit got = 0;
    ld_req = 1; ld_we = we; ld_lock = lk; ld_addr = a; ld_wdata = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ld_ack) begin got = 1; break; end
    end
    if (!got) chk("ld_ack_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) ld_req = 0;
  endtask

  initial begin
    int na, ns;
    rst = 1'b0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;

    // CPU-only read with cycle-exact latency
    preload(13'h1A3, 8'h5C);
    do_reset();
    push(0, 1, 8'h5C);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1A3;
    @(negedge clk);
    chk("rd_n_stall", cpu_stall, 1);
    chk("rd_n_strobe", {mem_read, mem_write}, 2'b00);
    @(negedge clk);
    chk("rd_n1_strobe", {mem_read, mem_write}, 2'b10);
    chk("rd_n1_addr", mem_address, 13'h1A3);
    chk("rd_n1_stall", cpu_stall, 1);
    @(negedge clk);
    chk("rd_n2_ack", cpu_ack, 1);
    chk("rd_n2_stall", cpu_stall, 0);
    chk("rd_n2_rdata", cpu_rdata, 8'h5C);
    @(posedge clk); #1;
    cpu_req = 0;
    // a write leaves cpu_rdata alone
    push(0, 0, 8'h00);
    cpu_access(1, 13'h050, 8'h77, 0);
    chk("wr_keeps_rdata", cpu_rdata, 8'h5C);
    chk("wr_mem", mem[13'h050], 8'h77);

    // Simultaneous writes after reset: CPU first
    do_reset();
    push(0, 0, 8'h00);
    push(1, 0, 8'h00);
    fork
      cpu_access(1, 13'h010, 8'h11, 0);
      ld_access(1, 0, 13'h020, 8'h22, 0);
    join
    chk("tie_spacing", ld_ack_cyc - cpu_ack_cyc, 3);
    chk("tie_mem_cpu", mem[13'h010], 8'h11);
    chk("tie_mem_ld", mem[13'h020], 8'h22);

    // Round robin over 6 reads
    for (int i = 0; i < 3; i++) preload(13'h100 + 13'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) preload(13'h200 + 13'(i), 8'hB0 + 8'(i));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 8'hA0 + 8'(i));
      push(1, 1, 8'hB0 + 8'(i));
    end
    fork
      for (int i = 0; i < 3; i++)
        cpu_access(0, 13'h100 + 13'(i), 8'h00, i != 2);
      for (int j = 0; j < 3; j++)
        ld_access(0, 0, 13'h200 + 13'(j), 8'h00, j != 2);
    join

    // Locked burst: L L L L C L L L L C
    for (int i = 0; i < 2; i++) preload(13'h300 + 13'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 8; i++) preload(13'h400 + 13'(i), 8'hD0 + 8'(i));
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 1, 8'hD0 + 8'(i));
    push(0, 1, 8'hC0);
    for (int i = 4; i < 8; i++) push(1, 1, 8'hD0 + 8'(i));
    push(0, 1, 8'hC1);
    fork
      for (int i = 0; i < 2; i++)
        cpu_access(0, 13'h300 + 13'(i), 8'h00, i != 1);
      for (int j = 0; j < 8; j++)
        ld_access(0, 1, 13'h400 + 13'(j), 8'h00, j != 7);
    join

    // Reset in the middle of a loader write
    do_reset();
    @(posedge clk); #1;
    ld_req = 1; ld_we = 1; ld_lock = 0; ld_addr = 13'h030; ld_wdata = 8'h99;
    @(negedge clk);
    @(negedge clk);
    chk("mid_grant_write", mem_write, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_strobe", {mem_read, mem_write, busy}, 3'b000);
    chk("mid_rst_addr", mem_address, 13'h0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_ack", ld_ack, 0);
    push(1, 0, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_grant_write", mem_write, 1);
    @(posedge clk);
    @(negedge clk);
    chk("rel_ld_ack", ld_ack, 1);
    @(posedge clk); #1;
    ld_req = 0;
    @(negedge clk);
    chk("rel_mem", mem[13'h030], 8'h99);

    // Withdrawn CPU read still completes exactly once
    preload(13'h0F0, 8'hE5);
    do_reset();
    push(0, 1, 8'hE5);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0F0;
    @(posedge clk); #1;
    cpu_req = 0;
    na = 0;
    ns = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack) na++;
      if (mem_read || mem_write) ns++;
    end
    chk("wd_ack_count", na, 1);
    chk("wd_strobe_count", ns, 1);

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 13, meaning memory address width (matches PC/TR width).
- REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning memory word width.
- REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive locked loader grants while the CPU waits.
- REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
- REQ-005 SHALL have port rst, input, 1, reset: asynchronous and active-low.
- REQ-006 SHALL have CPU-side ports: cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_WIDTH, cpu_wdata in DATA_WIDTH, cpu_ack out 1, cpu_rdata out DATA_WIDTH, cpu_stall out 1.
- REQ-007 SHALL have loader-side ports: ld_req in 1, ld_we in 1, ld_lock in 1, ld_addr in ADDR_WIDTH, ld_wdata in DATA_WIDTH, ld_ack out 1, ld_rdata out DATA_WIDTH.
- REQ-008 SHALL have memory-side ports: mem_address out ADDR_WIDTH, mem_write_data out DATA_WIDTH, mem_read out 1, mem_write out 1, mem_read_data in DATA_WIDTH (combinational read).
- REQ-009 SHALL have port busy, out 1, high whenever the FSM is not in IDLE.

Function
- REQ-010 SHALL implement FSM states IDLE, GRANT_CPU, GRANT_LD, ACK_CPU, ACK_LD.
- REQ-011 In IDLE: if exactly one req is high, SHALL go to that requester's GRANT state next cycle; if none, stay in IDLE.
- REQ-012 In IDLE with both reqs high, SHALL grant per a one-bit round-robin pointer `last`: grant the requester not equal to `last`.
- REQ-013 Lock override: if `last`=LD, ld_lock=1 and burst_cnt<MAX_BURST, the loader SHALL win the tie.
- REQ-014 In GRANT_x, SHALL drive mem_address/mem_write_data from requester x's inputs.
  - Assert mem_write if x_we=1, else mem_read, for exactly that one cycle.
  - Register mem_read_data into x_rdata at the cycle's end on reads only.
- REQ-015 GRANT_x SHALL always go to ACK_x; in ACK_x, x_ack SHALL be high for exactly one cycle with x_rdata valid; ACK_x SHALL always go to IDLE.
- REQ-016 Latency: req sampled high in IDLE at cycle n gives memory strobe at n+1 and x_ack at n+2; minimum 3 cycles per access.
- REQ-017 mem_read and mem_write SHALL never be high simultaneously, and both SHALL be low outside GRANT states.
- REQ-018 Outside GRANT states, mem_address and mem_write_data SHALL be 0.
- REQ-019 `last` SHALL update to the granted requester on entry to GRANT.
- REQ-020 burst_cnt (width clog2(MAX_BURST+1)):
  - Increments on each loader grant taken with ld_lock=1.
  - Clears on any CPU grant or any loader grant with ld_lock=0.
  - Saturates at MAX_BURST.
- REQ-021 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
- REQ-022 Requesters SHALL hold req and payload stable until ack.
  - If req drops during GRANT/ACK, the access SHALL still complete and ack SHALL still pulse.
  - Payload is sampled only in GRANT.
- REQ-023 x_rdata SHALL hold its last value until the next read by that requester; writes SHALL not alter it.

Reset
- REQ-024 On rst low, asynchronously and regardless of state: FSM=IDLE, `last`=LD (CPU wins first tie), burst_cnt=0, cpu_rdata=ld_rdata=0, all acks/strobes/busy=0, mem_address=mem_write_data=0.
- REQ-025 A reset asserted mid-GRANT SHALL abort the access with strobes low immediately; no ack SHALL be issued after release.
- REQ-026 After rst rises, the first grant decision SHALL occur at the first rising edge.

Verification
- REQ-027 CPU-only read: mem[0x1A3]=0x5C, cpu_req=1, cpu_we=0, cpu_addr=0x1A3 -> mem_read at n+1 with mem_address=0x1A3, cpu_ack at n+2, cpu_rdata=0x5C, cpu_stall high n..n+1.
- REQ-028 Simultaneous requests after reset: CPU write 0x11@0x010 and loader write 0x22@0x020, both held -> CPU granted first, loader second; ack spacing 3 cycles; memory ends 0x11/0x22.
- REQ-029 Round-robin: both requesting continuously for 6 accesses -> grants alternate CPU, LD, CPU, LD, CPU, LD.
- REQ-030 Locked burst with MAX_BURST=4: ld_lock=1, both requesting continuously, `last`=LD -> loader grants until burst_cnt=4, then exactly one CPU grant, then loader resumes.
- REQ-031 Reset mid-access: rst low during GRANT_LD of a write -> mem_write drops asynchronously, no ld_ack; after release, a held ld_req is re-granted and ld_ack arrives 2 cycles after the first edge.
- REQ-032 Request withdrawal: cpu_req dropped during GRANT_CPU -> cpu_ack still pulses once; no second access issued.
